// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: shares one combinational palette ROM between the world renderer
// (port 0) and the HUD/cursor overlay (port 1). Round-robin grant, one lookup per cycle,
// registered per-port responses with valid/ready backpressure and a sticky out-of-range flag.
// Optional feature macro: PALETTE_ARB_STATS_EN adds saturating grant/conflict counters.
module palette_lookup_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 12,
  parameter int unsigned           NUM_COLORS = 194,
  parameter logic [DATA_WIDTH-1:0] OOR_COLOR  = '0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  rsp0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  input  logic                  rsp1_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  oor_err
`ifdef PALETTE_ARB_STATS_EN
  ,
  output logic [15:0]           grant0_cnt,
  output logic [15:0]           grant1_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  // One extra bit so a NUM_COLORS equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] NUM_LIM = (ADDR_WIDTH + 1)'(NUM_COLORS);

  port_e                 last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic                  oor_err_q, oor_err_d;
  logic                  elig0, elig1, grant0, grant1, oor_hit;
  logic [DATA_WIDTH-1:0] cap_data;

  // Eligibility, round-robin grant, ROM address mux and response-slot next state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant0       = 1'b0;
    grant1       = 1'b0;
    last_grant_d = last_grant_q;
    rom_addr_d   = rom_addr_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    oor_err_d    = oor_err_q;

    // A port may only be granted if its response slot is empty or drains this cycle.
    elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);

    if (elig0 && elig1) begin
      if (last_grant_q == PORT1) grant0 = 1'b1;
      else                       grant1 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end

    // Address holds when idle so the ROM input does not toggle needlessly.
    if (grant0) begin
      rom_addr_d   = req0_addr;
      last_grant_d = PORT0;
    end else if (grant1) begin
      rom_addr_d   = req1_addr;
      last_grant_d = PORT1;
    end

    oor_hit  = ({1'b0, rom_addr_d} >= NUM_LIM);
    cap_data = oor_hit ? OOR_COLOR : rom_data;

    // A new accept overrides a drain so back-to-back lookups keep the slot full.
    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = cap_data;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = cap_data;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end

    if ((grant0 || grant1) && oor_hit) oor_err_d = 1'b1;
  end

  // State registers; reset discards any response in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant_q <= PORT1;
      rom_addr_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      oor_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      last_grant_q <= last_grant_d;
      rom_addr_q   <= rom_addr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      oor_err_q    <= oor_err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rom_addr   = rom_addr_d;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign oor_err    = oor_err_q;

`ifdef PALETTE_ARB_STATS_EN
  logic [15:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;

  // Saturating event counters: grants per port and cycles with both ports eligible.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grant0_cnt_q   <= '0;
      grant1_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (grant0 && (grant0_cnt_q != 16'hFFFF)) grant0_cnt_q <= grant0_cnt_q + 16'd1;
      if (grant1 && (grant1_cnt_q != 16'hFFFF)) grant1_cnt_q <= grant1_cnt_q + 16'd1;
      if (elig0 && elig1 && (conflict_cnt_q != 16'hFFFF)) conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign grant0_cnt   = grant0_cnt_q;
  assign grant1_cnt   = grant1_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`else
  // Statistics disabled: no counters or counter ports exist in this build.
`endif

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed self-checking bench for palette_lookup_arbiter. The palette ROM is modelled as
// rom_data = {4'hA, rom_addr}, so ROM[n] is 12'hA00 | n.
module tb_palette_lookup_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [7:0]  req0_addr, req1_addr, rom_addr;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, oor_err;
  logic [11:0] rsp0_data, rsp1_data, rom_data;
`ifdef PALETTE_ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  assign rom_data = {4'hA, rom_addr};

  palette_lookup_arbiter dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_ready (rsp0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_ready (rsp1_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .oor_err    (oor_err)
`ifdef PALETTE_ARB_STATS_EN
    ,
    .grant0_cnt   (grant0_cnt),
    .grant1_cnt   (grant1_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Combinational grant outputs, sampled shortly after the inputs settle.
  task automatic comb(input string t, input logic r0, input logic r1, input logic [7:0] a);
    #1;
    check({t, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    check({t, ".req1_ready"}, 32'(req1_ready), 32'(r1));
    check({t, ".rom_addr"},   32'(rom_addr),   32'(a));
  endtask

  // Registered response state after a clock edge; data only checked where a response is expected.
  task automatic resp(input string t, input logic v0, input logic [11:0] d0,
                      input logic v1, input logic [11:0] d1, input logic e);
    check({t, ".rsp0_valid"}, 32'(rsp0_valid), 32'(v0));
    if (v0) check({t, ".rsp0_data"}, 32'(rsp0_data), 32'(d0));
    check({t, ".rsp1_valid"}, 32'(rsp1_valid), 32'(v1));
    if (v1) check({t, ".rsp1_data"}, 32'(rsp1_data), 32'(d1));
    check({t, ".oor_err"}, 32'(oor_err), 32'(e));
  endtask

  initial begin
    Reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 8'd0;  req1_addr = 8'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    // Reset state
    check("rst.rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst.rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst.rsp0_data",  32'(rsp0_data),  32'd0);
    check("rst.rsp1_data",  32'(rsp1_data),  32'd0);
    check("rst.oor_err",    32'(oor_err),    32'd0);
    check("rst.rom_addr",   32'(rom_addr),   32'd0);
    tick();
    Reset_n = 1'b1;

    // Single lookup on port 0, addr 3
    req0_valid = 1'b1; req0_addr = 8'd3; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    comb("t1", 1'b1, 1'b0, 8'd3);
    tick();
    resp("t1", 1'b1, 12'hA03, 1'b0, 12'h000, 1'b0);
    req0_valid = 1'b0;
    comb("t1_idle", 1'b0, 1'b0, 8'd3);
    tick();
    resp("t1_drain", 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);

    // Both ports continuously requesting; last grant was port 0, so port 1 goes first
    req0_valid = 1'b1; req0_addr = 8'd5; req1_valid = 1'b1; req1_addr = 8'd9;
    comb("t2c1", 1'b0, 1'b1, 8'd9); tick(); resp("t2c1", 1'b0, 12'h000, 1'b1, 12'hA09, 1'b0);
    comb("t2c2", 1'b1, 1'b0, 8'd5); tick(); resp("t2c2", 1'b1, 12'hA05, 1'b0, 12'h000, 1'b0);
    comb("t2c3", 1'b0, 1'b1, 8'd9); tick(); resp("t2c3", 1'b0, 12'h000, 1'b1, 12'hA09, 1'b0);
    comb("t2c4", 1'b1, 1'b0, 8'd5); tick(); resp("t2c4", 1'b1, 12'hA05, 1'b0, 12'h000, 1'b0);

    // Port 1 backpressured: its slot holds, port 0 takes every cycle, release accepts at once
    req0_addr = 8'd6; req1_addr = 8'd7; rsp1_ready = 1'b0;
    comb("t3c1", 1'b0, 1'b1, 8'd7); tick(); resp("t3c1", 1'b0, 12'h000, 1'b1, 12'hA07, 1'b0);
    comb("t3c2", 1'b1, 1'b0, 8'd6); tick(); resp("t3c2", 1'b1, 12'hA06, 1'b1, 12'hA07, 1'b0);
    req1_addr = 8'd8;
    comb("t3c3", 1'b1, 1'b0, 8'd6); tick(); resp("t3c3", 1'b1, 12'hA06, 1'b1, 12'hA07, 1'b0);
    rsp1_ready = 1'b1;
    comb("t3c4", 1'b0, 1'b1, 8'd8); tick(); resp("t3c4", 1'b0, 12'h000, 1'b1, 12'hA08, 1'b0);

    // Out-of-range boundary: 193 is the last valid index, 194 and 200 are out of range
    req1_valid = 1'b0; req0_addr = 8'd193;
    comb("t4_193", 1'b1, 1'b0, 8'd193); tick(); resp("t4_193", 1'b1, 12'hAC1, 1'b0, 12'h000, 1'b0);
    req0_addr = 8'd194;
    comb("t4_194", 1'b1, 1'b0, 8'd194); tick(); resp("t4_194", 1'b1, 12'h000, 1'b0, 12'h000, 1'b1);
    req0_addr = 8'd200;
    comb("t4_200", 1'b1, 1'b0, 8'd200); tick(); resp("t4_200", 1'b1, 12'h000, 1'b0, 12'h000, 1'b1);
    req0_addr = 8'd4;
    comb("t4_4", 1'b1, 1'b0, 8'd4); tick(); resp("t4_sticky", 1'b1, 12'hA04, 1'b0, 12'h000, 1'b1);

    // Reset mid-traffic: outputs clear before any clock edge
    req0_addr = 8'd1; req1_valid = 1'b1; req1_addr = 8'd2; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    Reset_n = 1'b0;
    #1;
    check("t5.rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("t5.rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("t5.rsp0_data",  32'(rsp0_data),  32'd0);
    check("t5.oor_err",    32'(oor_err),    32'd0);
    tick();
    Reset_n = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    comb("t5a", 1'b1, 1'b0, 8'd1); tick(); resp("t5a", 1'b1, 12'hA01, 1'b0, 12'h000, 1'b0);
    comb("t5b", 1'b0, 1'b1, 8'd2); tick(); resp("t5b", 1'b0, 12'h000, 1'b1, 12'hA02, 1'b0);

`ifdef PALETTE_ARB_STATS_EN
    // Counter saturation
    req1_valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("t6.grant0_cnt_rst", 32'(grant0_cnt), 32'd0);
    check("t6.conflict_rst",   32'(conflict_cnt), 32'd0);
    tick();
    Reset_n = 1'b1;
    repeat (65540) tick();
    check("t6.grant0_cnt_sat", 32'(grant0_cnt), 32'hFFFF);
    check("t6.grant1_cnt",     32'(grant1_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
